// File: rtl/lb_tx_frame_sender.sv
// lb_tx_frame_sender
// Pulls one length-prefixed frame out of the TX byte buffer and streams it
// downstream over valid/ready, followed by a CRC-16/CCITT-FALSE trailer
// (high byte first). The buffer has a one-cycle registered read. A two-entry
// prefetch FIFO hides that read latency so the stream can move one beat per
// clock. The FIFO is the output register plus one skid register.
module lb_tx_frame_sender #(
    parameter int ADDR_W    = 11,
    parameter int BASE_ADDR = 0,
    parameter int MAX_LEN   = 2046
) (
    input  logic              sys_clk_50m,
    input  logic              sys_rst,
    input  logic              tx_start,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_err,
    output logic              buf_rden,
    output logic [ADDR_W-1:0] buf_raddr,
    input  logic [7:0]        buf_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_RD,
        CHECK,
        PAYLOAD,
        CRC_HI,
        CRC_LO
    } state_t;

    localparam logic [15:0]       MAX_LEN_V   = 16'(MAX_LEN);
    localparam logic [ADDR_W-1:0] LEN_HI_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LEN_LO_ADDR = ADDR_W'(BASE_ADDR + 1);

    state_t            state;
    logic              armed;
    logic [1:0]        len_phase;
    logic [7:0]        len_hi;
    logic [15:0]       len;
    logic [15:0]       rd_cnt;
    logic [15:0]       tx_cnt;
    logic              data_due;
    logic [7:0]        skid_data;
    logic              skid_valid;
    logic [15:0]       crc;

    logic              pop;
    logic              len_ok;
    logic              rd_go;
    logic [1:0]        occ_after;
    logic [ADDR_W-1:0] pay_addr;

    // One CRC-16/CCITT-FALSE byte step: MSB first, poly 0x1021, no reflection.
    function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign pop       = tx_valid & tx_ready;
    assign len_ok    = (len != 16'd0) && (len <= MAX_LEN_V);
    assign occ_after = {1'b0, tx_valid} + {1'b0, skid_valid} - {1'b0, pop} + {1'b0, data_due};
    assign pay_addr  = ADDR_W'(BASE_ADDR + 2 + int'(rd_cnt));

    // Read port control. The LEN bytes are read back to back on entry.
    // A payload read is issued only if the byte it fetches is certain to find
    // room. That means: entries left after this edge's pop, plus the byte being
    // captured now, must leave one slot free. rden looks at this cycle's pop,
    // which lets the FIFO sustain one beat per clock with only two entries.
    always_comb begin
        rd_go     = 1'b0;
        buf_rden  = 1'b0;
        buf_raddr = '0;
        if (state == LEN_RD && len_phase == 2'd0) begin
            buf_rden  = 1'b1;
            buf_raddr = LEN_HI_ADDR;
        end else if (state == LEN_RD && len_phase == 2'd1) begin
            buf_rden  = 1'b1;
            buf_raddr = LEN_LO_ADDR;
        end else if ((state == CHECK && len_ok) || state == PAYLOAD) begin
            if (rd_cnt != len && occ_after < 2'd2) begin
                rd_go     = 1'b1;
                buf_rden  = 1'b1;
                buf_raddr = pay_addr;
            end
        end
    end

    // Frame sequencer, prefetch FIFO, CRC accumulation and all registered outputs.
    // The armed flag makes the first clock after reset release ignore tx_start.
    always_ff @(posedge sys_clk_50m or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            len_phase  <= 2'd0;
            len_hi     <= 8'h00;
            len        <= 16'h0000;
            rd_cnt     <= 16'h0000;
            tx_cnt     <= 16'h0000;
            data_due   <= 1'b0;
            skid_data  <= 8'h00;
            skid_valid <= 1'b0;
            crc        <= 16'hFFFF;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            tx_last    <= 1'b0;
        end else begin
            armed    <= 1'b1;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
            data_due <= rd_go;
            if (rd_go) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (tx_start && armed) begin
                        state     <= LEN_RD;
                        tx_busy   <= 1'b1;
                        len_phase <= 2'd0;
                        rd_cnt    <= 16'h0000;
                        tx_cnt    <= 16'h0000;
                        crc       <= 16'hFFFF;
                    end
                end
                LEN_RD: begin
                    case (len_phase)
                        2'd0: len_phase <= 2'd1;
                        2'd1: begin
                            len_hi    <= buf_rdata;
                            len_phase <= 2'd2;
                        end
                        default: begin
                            len       <= {len_hi, buf_rdata};
                            len_phase <= 2'd0;
                            state     <= CHECK;
                        end
                    endcase
                end
                CHECK: begin
                    if (len_ok) begin
                        state <= PAYLOAD;
                    end else begin
                        tx_err  <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                PAYLOAD: begin
                    if (data_due) begin
                        crc <= crc_step(crc, buf_rdata);
                    end
                    if (pop) begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                    if (pop && tx_cnt == len - 16'd1) begin
                        tx_data  <= crc[15:8];
                        tx_valid <= 1'b1;
                        state    <= CRC_HI;
                    end else if (pop) begin
                        if (skid_valid) begin
                            tx_data    <= skid_data;
                            skid_valid <= data_due;
                            if (data_due) begin
                                skid_data <= buf_rdata;
                            end
                        end else begin
                            tx_valid <= data_due;
                            if (data_due) begin
                                tx_data <= buf_rdata;
                            end
                        end
                    end else if (data_due) begin
                        if (!tx_valid) begin
                            tx_valid <= 1'b1;
                            tx_data  <= buf_rdata;
                        end else begin
                            skid_valid <= 1'b1;
                            skid_data  <= buf_rdata;
                        end
                    end
                end
                CRC_HI: begin
                    if (pop) begin
                        tx_data <= crc[7:0];
                        tx_last <= 1'b1;
                        state   <= CRC_LO;
                    end
                end
                CRC_LO: begin
                    if (pop) begin
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                        tx_done  <= 1'b1;
                        tx_busy  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
